// File: rtl/score_pkg.sv
// Shared score types and widths, used by the score counter and the score-to-glyph decoder.
package score_pkg;

    localparam int MAX_SCORE_W   = 4;
    localparam int WIN_SCORE_DEF = 9;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_PLAYER,
        WIN_ENEMY
    } winner_t;

endpackage

// File: rtl/score_cooldown_timer.sv
// Frame-tick counter with synchronous clear. done_o is high in the cycle that
// carries the FRAMES-th counted tick; the owner registers it if needed.
module score_cooldown_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic tick_i,
    output logic done_o
);

    localparam int CW = $clog2(FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAMES - 1);
    localparam logic [CW-1:0] FULL = CW'(FRAMES);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && tick_i && count_q != FULL) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign done_o = enable_i && tick_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/game_score_counter.sv
// Pong score keeper: counts goals, enforces a frame-based cooldown before each
// serve, and latches the winner once a side reaches WIN_SCORE.
module game_score_counter
    import score_pkg::*;
#(
    parameter int WIN_SCORE       = WIN_SCORE_DEF,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   player_goal_i,
    input  logic                   enemy_goal_i,
    input  logic                   frame_tick_i,
    input  logic                   restart_i,
    output logic [MAX_SCORE_W-1:0] player_score_o,
    output logic [MAX_SCORE_W-1:0] enemy_score_o,
    output logic                   serve_o,
    output logic                   game_over_o,
    output winner_t                winner_o,
    output logic [1:0]             state_dbg_o
);

    typedef enum logic [1:0] {
        S_PLAY      = 2'd0,
        S_COOLDOWN  = 2'd1,
        S_GAME_OVER = 2'd2
    } state_t;

    localparam logic [MAX_SCORE_W-1:0] WIN_S = MAX_SCORE_W'(WIN_SCORE);

    state_t                 state_q, state_d;
    logic [MAX_SCORE_W-1:0] player_q, player_d, enemy_q, enemy_d;
    logic [MAX_SCORE_W-1:0] player_inc, enemy_inc;
    logic                   serve_q, serve_d, over_q, over_d;
    winner_t                winner_q, winner_d;
    logic                   goal_p, goal_e;
    logic                   timer_clear, timer_done;

    // Simultaneous goals cancel each other out.
    assign goal_p     = player_goal_i & ~enemy_goal_i;
    assign goal_e     = enemy_goal_i & ~player_goal_i;
    assign player_inc = player_q + MAX_SCORE_W'(1);
    assign enemy_inc  = enemy_q + MAX_SCORE_W'(1);

    score_cooldown_timer #(
        .FRAMES (COOLDOWN_FRAMES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (timer_clear),
        .enable_i (state_q == S_COOLDOWN),
        .tick_i   (frame_tick_i),
        .done_o   (timer_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_PLAY;
            player_q <= '0;
            enemy_q  <= '0;
            serve_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            enemy_q  <= enemy_d;
            serve_q  <= serve_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart_i) begin
            state_d = S_COOLDOWN;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (goal_p) begin
                        state_d = (player_inc == WIN_S) ? S_GAME_OVER : S_COOLDOWN;
                    end else if (goal_e) begin
                        state_d = (enemy_inc == WIN_S) ? S_GAME_OVER : S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (timer_done) state_d = S_PLAY;
                end
                S_GAME_OVER: state_d = S_GAME_OVER;
                default:     state_d = S_PLAY;
            endcase
        end
    end

    // Next values for the registered outputs; restart overrides everything.
    always_comb begin
        player_d    = player_q;
        enemy_d     = enemy_q;
        serve_d     = 1'b0;
        over_d      = over_q;
        winner_d    = winner_q;
        timer_clear = 1'b0;
        if (restart_i) begin
            player_d    = '0;
            enemy_d     = '0;
            over_d      = 1'b0;
            winner_d    = WIN_NONE;
            timer_clear = 1'b1;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (goal_p) begin
                        player_d    = player_inc;
                        timer_clear = 1'b1;
                        if (player_inc == WIN_S) begin
                            over_d   = 1'b1;
                            winner_d = WIN_PLAYER;
                        end
                    end else if (goal_e) begin
                        enemy_d     = enemy_inc;
                        timer_clear = 1'b1;
                        if (enemy_inc == WIN_S) begin
                            over_d   = 1'b1;
                            winner_d = WIN_ENEMY;
                        end
                    end
                end
                S_COOLDOWN: serve_d = timer_done;
                default: ;
            endcase
        end
    end

    assign player_score_o = player_q;
    assign enemy_score_o  = enemy_q;
    assign serve_o        = serve_q;
    assign game_over_o    = over_q;
    assign winner_o       = winner_q;
    assign state_dbg_o    = state_q;

endmodule
